bus_arbiter: RTL

- Shared-bus arbiter and master multiplexer.
- Sits directly downstream of each master-side bus interface unit (CPU instruction/data ports, DMA, debug master) and upstream of the slave decoder.
- Consumes each master's active-low request, returns one active-low grant using round-robin with parking, and drives the granted master's address/strobe/rw/write-data onto the shared bus.

---
 rtl/bus_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: four-master shared-bus arbiter and master multiplexer.
// The arbiter is round-robin with parking. The current owner keeps the bus
// for as long as it holds its request. When the owner releases, the next
// requester is searched in the order owner+1, owner+2, owner+3 (mod 4).
// If no other master is requesting, the owner stays parked on the bus.
//
// Ports:
//   clk        system clock; all state changes on posedge
//   reset      asynchronous active-low reset; parks the bus on master 0
//   m_req_     per-master request, active-low (bit i = master i)
//   m_grnt_    per-master grant, active-low; exactly one bit is low at all times
//   m_addr     packed master word addresses, master i at [i*ADDR_W +: ADDR_W]
//   m_as_      per-master address strobe, active-low
//   m_rw       per-master read(1)/write(0)
//   m_wr_data  packed master write data, master i at [i*DATA_W +: DATA_W]
//   bus_owner  registered index of the current owner
//   s_addr, s_as_, s_rw, s_wr_data  the owner's fields, driven onto the shared bus
module bus_arbiter #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          m_req_,
  output logic [3:0]          m_grnt_,
  input  logic [4*ADDR_W-1:0] m_addr,
  input  logic [3:0]          m_as_,
  input  logic [3:0]          m_rw,
  input  logic [4*DATA_W-1:0] m_wr_data,
  output logic [1:0]          bus_owner,
  output logic [ADDR_W-1:0]   s_addr,
  output logic                s_as_,
  output logic                s_rw,
  output logic [DATA_W-1:0]   s_wr_data
);

  localparam int NUM_M = 4;

  logic [1:0]                   r_owner;
  logic [1:0]                   w_next;
  logic [1:0]                   w_c1, w_c2, w_c3;
  logic [NUM_M-1:0][ADDR_W-1:0] w_addr;
  logic [NUM_M-1:0][DATA_W-1:0] w_data;

  // View the flat port vectors as per-master arrays.
  // The packed widths match, so this is a plain reinterpretation of the bits.
  assign w_addr = m_addr;
  assign w_data = m_wr_data;

  // The round-robin candidates are 2-bit sums, so wrapping from 3 to 0 is free.
  assign w_c1 = r_owner + 2'd1;
  assign w_c2 = r_owner + 2'd2;
  assign w_c3 = r_owner + 2'd3;

  always_comb begin
    w_next = r_owner;
    // An owner whose request is still low keeps the bus. This also covers an
    // owner that releases and re-requests in the same cycle.
    if (m_req_[r_owner])  begin
      if      (!m_req_[w_c1]) w_next = w_c1;
      else if (!m_req_[w_c2]) w_next = w_c2;
      else if (!m_req_[w_c3]) w_next = w_c3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_owner <= 2'd0;
    else        r_owner <= w_next;
  end

  assign bus_owner = r_owner;

  // The grant and the bus mux decode only the owner register. The async
  // reset clears that register, so both switch to master 0 at once, without
  // waiting for a clock edge.
  always_comb begin
    case (r_owner)
      2'd1:    m_grnt_ = 4'b1101;
      2'd2:    m_grnt_ = 4'b1011;
      2'd3:    m_grnt_ = 4'b0111;
      default: m_grnt_ = 4'b1110;
    endcase
  end

  always_comb begin
    case (r_owner)
      2'd1: begin
        s_addr = w_addr[1]; s_as_ = m_as_[1]; s_rw = m_rw[1]; s_wr_data = w_data[1];
      end
      2'd2: begin
        s_addr = w_addr[2]; s_as_ = m_as_[2]; s_rw = m_rw[2]; s_wr_data = w_data[2];
      end
      2'd3: begin
        s_addr = w_addr[3]; s_as_ = m_as_[3]; s_rw = m_rw[3]; s_wr_data = w_data[3];
      end
      default: begin
        s_addr = w_addr[0]; s_as_ = m_as_[0]; s_rw = m_rw[0]; s_wr_data = w_data[0];
      end
    endcase
  end

endmodule
